md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and owns the HI/LO registers. It sequences MULT/MULTU/DIV/DIVU over a fixed cycle count and applies MTHI/MTLO writes. It reports `busy` so the hazard unit can stall any HI/LO-class instruction in D. Results are computed combinationally at start, held in a pending register, and committed to HI/LO after the programmed latency, which models the iterative hardware timing.

---
 rtl/md_unit_if.sv | 15 +
 rtl/md_unit.sv | 118 +++++++++++
 tb/tb_md_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Multiply/divide request bundle between E-stage issue logic and md_unit.
// The issuing side drives the request; md_unit returns busy and the HI/LO registers.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic        flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, md_op, flush, A, B, input busy, HI, LO);
   modport slave  (input start, md_op, flush, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO: result computed at accept, committed after N busy cycles.
// No backpressure input; requests arriving while busy are dropped, so the hazard unit must stall on busy.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   md_unit_if.slave  md
);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [63:0] pend_q;
   logic        dz_q;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        accept;
   logic        is_sdiv;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, uq, ur, quot, rem;
   logic signed [63:0] sa64, sb64, prod_s;
   logic [63:0] prod_u;
   logic [63:0] pend_d;

   assign accept = md.start && !md.flush && (state_q == IDLE)
                   && (md.md_op >= OP_MULT) && (md.md_op <= OP_MTLO);

   // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with no trap.
   always_comb begin
      is_sdiv = (md.md_op == OP_DIV);
      a_neg   = md.A[31] && is_sdiv;
      b_neg   = md.B[31] && is_sdiv;
      a_mag   = a_neg ? -md.A : md.A;
      b_mag   = (md.B == 32'd0) ? 32'd1 : (b_neg ? -md.B : md.B);
      uq      = a_mag / b_mag;
      ur      = a_mag % b_mag;
      quot    = (a_neg ^ b_neg) ? -uq : uq;
      rem     = a_neg ? -ur : ur;
      sa64    = {{32{md.A[31]}}, md.A};
      sb64    = {{32{md.B[31]}}, md.B};
      prod_s  = sa64 * sb64;
      prod_u  = {32'd0, md.A} * {32'd0, md.B};
      pend_d  = {rem, quot};
      if (md.md_op == OP_MULT)
         pend_d = prod_s;
      else if (md.md_op == OP_MULTU)
         pend_d = prod_u;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 64'd0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  case (md.md_op)
                     OP_MULT, OP_MULTU: begin
                        pend_q  <= pend_d;
                        dz_q    <= 1'b0;
                        cnt_q   <= 4'(MULT_CYCLES);
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        pend_q  <= pend_d;
                        dz_q    <= (md.B == 32'd0);
                        cnt_q   <= 4'(DIV_CYCLES);
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                     end
                     OP_MTHI: hi_q <= md.A;
                     OP_MTLO: lo_q <= md.A;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  // Divide-by-zero burns the same cycles but leaves HI/LO untouched.
                  if (!dz_q) begin
                     hi_q <= pend_q[63:32];
                     lo_q <= pend_q[31:0];
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign md.busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed + random bench for md_unit; expected HI/LO come from a 64-bit reference model via a scoreboard queue.
module tb_md_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;
   logic [63:0] sb[$];

   md_unit_if mif();
   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mif));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
      longint sa, sb_, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = {{32{a[31]}}, a};
      sb_ = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return sa * sb_;
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return cur;
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return cur;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         3'd5: return {a, cur[31:0]};
         3'd6: return {cur[63:32], a};
         default: return cur;
      endcase
   endfunction

   // One-cycle request; the expected HI/LO is queued only when the bench expects acceptance.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl);
      if (!fl && op >= 3'd1 && op <= 3'd6)
         sb.push_back(model(op, a, b, {hi_m, lo_m}));
      mif.start = 1'b1;
      mif.md_op = op;
      mif.A     = a;
      mif.B     = b;
      mif.flush = fl;
      cyc();
      mif.start = 1'b0;
      mif.flush = 1'b0;
      mif.md_op = 3'd0;
   endtask

   // Counts busy cycles (bounded), checks HI/LO hold meanwhile, then compares against the queue head.
   task automatic wait_done(input string tag, input int exp_n);
      int n;
      logic [63:0] e;
      n = 0;
      while (mif.busy === 1'b1 && n < 40) begin
         check({tag, "_hold"}, {mif.HI, mif.LO}, {hi_m, lo_m});
         n++;
         cyc();
      end
      check({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_hilo"}, {mif.HI, mif.LO}, e);
         hi_m = e[63:32];
         lo_m = e[31:0];
      end
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      mif.start = 1'b0;
      mif.md_op = 3'd0;
      mif.flush = 1'b0;
      mif.A     = 32'd0;
      mif.B     = 32'd0;
      cyc();
      cyc();
      reset = 1'b0;
      check("reset_busy", 64'(mif.busy), 64'd0);
      check("reset_hilo", {mif.HI, mif.LO}, 64'd0);

      issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      wait_done("mult", 5);
      check("mult_const", {mif.HI, mif.LO}, 64'hFFFFFFFF_FFFFFFFE);
      issue(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      wait_done("multu", 5);
      check("multu_const", {mif.HI, mif.LO}, 64'h00000001_FFFFFFFE);
      issue(3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      wait_done("div_neg", 10);
      check("div_neg_const", {mif.HI, mif.LO}, 64'hFFFFFFFF_FFFFFFFD);
      issue(3'd4, 32'd7, 32'd2, 1'b0);
      wait_done("divu", 10);
      check("divu_const", {mif.HI, mif.LO}, 64'h00000001_00000003);
      issue(3'd4, 32'd55, 32'd0, 1'b0);
      wait_done("divu_zero", 10);
      check("divu_zero_const", {mif.HI, mif.LO}, 64'h00000001_00000003);
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      wait_done("div_ovf", 10);
      check("div_ovf_const", {mif.HI, mif.LO}, 64'h00000000_80000000);

      issue(3'd1, 32'd3, 32'd4, 1'b1);
      check("flush_busy", 64'(mif.busy), 64'd0);
      cyc();
      check("flush_hilo", {mif.HI, mif.LO}, {hi_m, lo_m});

      issue(3'd0, 32'd9, 32'd9, 1'b0);
      issue(3'd7, 32'd9, 32'd9, 1'b0);
      check("noop_busy", 64'(mif.busy), 64'd0);
      check("noop_hilo", {mif.HI, mif.LO}, {hi_m, lo_m});

      issue(3'd4, 32'd100, 32'd7, 1'b0);
      issue(3'd6, 32'h12345678, 32'd0, 1'b1);
      mif.start = 1'b1;
      mif.md_op = 3'd6;
      mif.A     = 32'h12345678;
      cyc();
      mif.start = 1'b0;
      mif.md_op = 3'd0;
      wait_done("mtlo_busy", 8);
      check("mtlo_busy_lo", 64'(mif.LO), 64'd14);

      issue(3'd6, 32'h12345678, 32'd0, 1'b0);
      wait_done("mtlo_idle", 0);
      check("mtlo_idle_lo", 64'(mif.LO), 64'h12345678);
      issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
      wait_done("mthi_idle", 0);
      check("mthi_idle_hi", 64'(mif.HI), 64'hCAFEF00D);

      for (int i = 0; i < 8; i++) begin
         rop = 3'(1 + $urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         if (i == 2) rb = 32'hFFFFFFF0;
         issue(rop, ra, rb, 1'b0);
         wait_done($sformatf("rand%0d_op%0d", i, rop), (rop <= 3'd2) ? 5 : 10);
      end

      mif.start = 1'b1;
      mif.md_op = 3'd3;
      mif.A     = 32'd1000;
      mif.B     = 32'd3;
      cyc();
      mif.start = 1'b0;
      mif.md_op = 3'd0;
      cyc();
      cyc();
      check("rst_mid_busy_before", 64'(mif.busy), 64'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      hi_m = 32'd0;
      lo_m = 32'd0;
      check("rst_mid_busy", 64'(mif.busy), 64'd0);
      check("rst_mid_hilo", {mif.HI, mif.LO}, 64'd0);
      for (int i = 0; i < 12; i++) cyc();
      check("rst_no_late_commit", {mif.HI, mif.LO}, 64'd0);
      check("rst_idle_busy", 64'(mif.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
